// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack feeding the ALU; BINOP collapses NOS/TOS into the ALU result.
// Optional DUP/SWAP commands are enabled by defining OPSTACK_DUP_SWAP_EN.
module operand_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    input  logic [WIDTH-1:0]           alu_result,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       pop_valid,
    output logic                       underflow,
    output logic                       overflow
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_PUSH  = 3'b001;
    localparam logic [2:0] CMD_POP   = 3'b010;
    localparam logic [2:0] CMD_BINOP = 3'b011;
`ifdef OPSTACK_DUP_SWAP_EN
    localparam logic [2:0] CMD_DUP   = 3'b100;
    localparam logic [2:0] CMD_SWAP  = 3'b101;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DW-1:0]    sp_r;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    tos_idx_s;
    logic [AW-1:0]    nos_idx_s;
    logic             empty_s;
    logic             full_s;
    logic             sp_ge2_s;
    logic             accept_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             do_binop_s;
    logic             do_dup_s;
    logic             do_swap_s;
    logic             set_ovf_s;
    logic             set_udf_s;

    // Indices are only used when the corresponding entry exists, so truncation is safe.
    assign top_idx_s = AW'(sp_r);
    assign tos_idx_s = AW'(sp_r - DW'(1));
    assign nos_idx_s = AW'(sp_r - DW'(2));
    assign empty_s   = (sp_r == DW'(0));
    assign full_s    = (sp_r == DW'(DEPTH));
    assign sp_ge2_s  = (sp_r >= DW'(2));
    assign cmd_ready = (state_r == ST_IDLE);
    assign accept_s  = cmd_valid & cmd_ready;
    assign depth     = sp_r;
    assign empty     = empty_s;
    assign full      = full_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command decode, error classification and next-state.
    always_comb begin
        state_s    = state_r;
        do_push_s  = 1'b0;
        do_pop_s   = 1'b0;
        do_binop_s = 1'b0;
        do_dup_s   = 1'b0;
        do_swap_s  = 1'b0;
        set_ovf_s  = 1'b0;
        set_udf_s  = 1'b0;
        if (state_r == ST_EXEC) begin
            state_s = ST_IDLE;
        end else if (accept_s) begin
            case (cmd)
                CMD_NOP: begin
                    state_s = ST_IDLE;
                end
                CMD_PUSH: begin
                    if (full_s) set_ovf_s = 1'b1;
                    else        do_push_s = 1'b1;
                end
                CMD_POP: begin
                    if (empty_s) set_udf_s = 1'b1;
                    else         do_pop_s  = 1'b1;
                end
                CMD_BINOP: begin
                    if (!sp_ge2_s) begin
                        set_udf_s = 1'b1;
                    end else begin
                        do_binop_s = 1'b1;
                        state_s    = ST_EXEC;
                    end
                end
`ifdef OPSTACK_DUP_SWAP_EN
                CMD_DUP: begin
                    if (empty_s)     set_udf_s = 1'b1;
                    else if (full_s) set_ovf_s = 1'b1;
                    else             do_dup_s  = 1'b1;
                end
                CMD_SWAP: begin
                    if (!sp_ge2_s) set_udf_s = 1'b1;
                    else           do_swap_s = 1'b1;
                end
`endif
                default: begin
                    set_ovf_s = 1'b1;
                    set_udf_s = 1'b1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Stack storage, pointer, ALU operand capture, pop port and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r      <= DW'(0);
            alu_a     <= {WIDTH{1'b0}};
            alu_b     <= {WIDTH{1'b0}};
            pop_data  <= {WIDTH{1'b0}};
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pop_valid <= 1'b0;
            if (set_ovf_s) overflow  <= 1'b1;
            if (set_udf_s) underflow <= 1'b1;
            // End of EXEC: the ALU result replaces NOS and TOS is dropped.
            if (state_r == ST_EXEC) begin
                mem_r[nos_idx_s] <= alu_result;
                sp_r             <= sp_r - DW'(1);
            end
            if (do_push_s) begin
                mem_r[top_idx_s] <= push_data;
                sp_r             <= sp_r + DW'(1);
            end
            if (do_pop_s) begin
                pop_data  <= mem_r[tos_idx_s];
                pop_valid <= 1'b1;
                sp_r      <= sp_r - DW'(1);
            end
            if (do_binop_s) begin
                alu_a <= mem_r[nos_idx_s];
                alu_b <= mem_r[tos_idx_s];
            end
            if (do_dup_s) begin
                mem_r[top_idx_s] <= mem_r[tos_idx_s];
                sp_r             <= sp_r + DW'(1);
            end
            if (do_swap_s) begin
                mem_r[tos_idx_s] <= mem_r[nos_idx_s];
                mem_r[nos_idx_s] <= mem_r[tos_idx_s];
            end
        end
    end

    // Top-of-stack view, forced to zero when empty.
    always_comb begin
        if (empty_s) begin
            tos = {WIDTH{1'b0}};
        end else begin
            tos = mem_r[tos_idx_s];
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack; the ALU is modelled as SUB or SHL.
module tb_operand_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd = 3'b000;
    logic [7:0] push_data = 8'h00;
    logic [7:0] alu_a, alu_b, alu_result, tos, pop_data;
    logic [3:0] depth;
    logic       empty, full, pop_valid, underflow, overflow;
    logic       alu_shl = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    operand_stack #(.DEPTH(8), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .push_data(push_data), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .tos(tos), .depth(depth), .empty(empty), .full(full), .pop_data(pop_data),
        .pop_valid(pop_valid), .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign alu_result = alu_shl ? (alu_a << alu_b) : (alu_a - alu_b);

    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c; push_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = 3'b000;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd = 3'b001; push_data = 8'h55;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0; cmd = 3'b000; reset = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b exp 1", cmd_ready); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b exp 1", empty); end
        n_cmp++; if (depth !== 4'd0) begin n_err++; $display("FAIL rst_depth got %0d exp 0", depth); end
        n_cmp++; if (tos !== 8'h00) begin n_err++; $display("FAIL rst_tos got %0h exp 0", tos); end
        n_cmp++; if ({full, pop_valid, underflow, overflow} !== 4'b0000) begin n_err++; $display("FAIL rst_flags got %b exp 0000", {full, pop_valid, underflow, overflow}); end
        n_cmp++; if ({alu_a, alu_b, pop_data} !== 24'h000000) begin n_err++; $display("FAIL rst_data got %h exp 000000", {alu_a, alu_b, pop_data}); end
    endtask

    task automatic test_binop();
        do_reset();
        alu_shl = 1'b0;
        issue(3'b001, 8'd5);
        issue(3'b001, 8'd3);
        issue(3'b011, 8'd0);
        cmd_valid = 1'b1; cmd = 3'b001; push_data = 8'd6;
        n_cmp++; if ({alu_a, alu_b} !== {8'd5, 8'd3}) begin n_err++; $display("FAIL sub_operands got %h exp 0503", {alu_a, alu_b}); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL exec_ready got %0b exp 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_exec_ready got %0b exp 1", cmd_ready); end
        n_cmp++; if (tos !== 8'd2) begin n_err++; $display("FAIL sub_tos got %0d exp 2", tos); end
        n_cmp++; if (depth !== 4'd1) begin n_err++; $display("FAIL sub_depth got %0d exp 1", depth); end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = 3'b000;
        n_cmp++; if ({depth, tos} !== {4'd2, 8'd6}) begin n_err++; $display("FAIL held_push got %h exp 206", {depth, tos}); end
        alu_shl = 1'b1;
        issue(3'b011, 8'd0);
        n_cmp++; if ({alu_a, alu_b} !== {8'd2, 8'd6}) begin n_err++; $display("FAIL shl_operands got %h exp 0206", {alu_a, alu_b}); end
        @(posedge clk); #1;
        n_cmp++; if ({depth, tos} !== {4'd1, 8'h80}) begin n_err++; $display("FAIL shl_result got %h exp 180", {depth, tos}); end
        alu_shl = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 1; v <= 8; v++) issue(3'b001, 8'(v));
        n_cmp++; if ({full, overflow, depth} !== {1'b1, 1'b0, 4'd8}) begin n_err++; $display("FAIL fill got %b exp 101000", {full, overflow, depth}); end
        issue(3'b001, 8'd9);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        n_cmp++; if ({tos, depth, full} !== {8'd8, 4'd8, 1'b1}) begin n_err++; $display("FAIL ovf_state got %h exp %h", {tos, depth, full}, {8'd8, 4'd8, 1'b1}); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL ovf_udf got %0b exp 0", underflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(3'b010, 8'd0);
        n_cmp++; if ({underflow, overflow, pop_valid} !== 3'b100) begin n_err++; $display("FAIL udf_pop got %b exp 100", {underflow, overflow, pop_valid}); end
        @(posedge clk); #1;
        n_cmp++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL udf_no_pop_valid got %0b exp 0", pop_valid); end
        issue(3'b001, 8'd7);
        issue(3'b011, 8'd0);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL udf_binop_no_exec got %0b exp 1", cmd_ready); end
        n_cmp++; if ({depth, tos, underflow, overflow} !== {4'd1, 8'd7, 1'b1, 1'b0}) begin n_err++; $display("FAIL udf_binop_state got %h exp %h", {depth, tos, underflow, overflow}, {4'd1, 8'd7, 1'b1, 1'b0}); end
    endtask

    task automatic test_pop();
        do_reset();
        issue(3'b001, 8'hAA);
        issue(3'b000, 8'h00);
        n_cmp++; if ({depth, tos} !== {4'd1, 8'hAA}) begin n_err++; $display("FAIL nop got %h exp 1aa", {depth, tos}); end
        issue(3'b010, 8'd0);
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'hAA}) begin n_err++; $display("FAIL pop_out got %h exp 1aa", {pop_valid, pop_data}); end
        n_cmp++; if ({empty, tos, depth} !== {1'b1, 8'h00, 4'd0}) begin n_err++; $display("FAIL pop_state got %h exp 1000", {empty, tos, depth}); end
        @(posedge clk); #1;
        n_cmp++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL pop_pulse got %0b exp 0", pop_valid); end
    endtask

    task automatic test_reset_exec();
        do_reset();
        issue(3'b001, 8'd1);
        issue(3'b001, 8'd2);
        issue(3'b110, 8'd0);
        n_cmp++; if ({overflow, underflow, depth, tos} !== {1'b1, 1'b1, 4'd2, 8'd2}) begin n_err++; $display("FAIL illegal got %h exp %h", {overflow, underflow, depth, tos}, {1'b1, 1'b1, 4'd2, 8'd2}); end
        issue(3'b011, 8'd0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        n_cmp++; if ({depth, overflow, underflow, cmd_ready, empty} !== {4'd0, 4'b0011}) begin n_err++; $display("FAIL rst_exec got %b exp 00000011", {depth, overflow, underflow, cmd_ready, empty}); end
        @(posedge clk); #1;
        n_cmp++; if (depth !== 4'd0) begin n_err++; $display("FAIL rst_exec_discard got %0d exp 0", depth); end
    endtask

    task automatic test_dup_swap();
        do_reset();
        issue(3'b001, 8'd4);
        issue(3'b001, 8'd9);
        issue(3'b101, 8'd0);
`ifdef OPSTACK_DUP_SWAP_EN
        n_cmp++; if ({tos, depth, overflow, underflow} !== {8'd4, 4'd2, 2'b00}) begin n_err++; $display("FAIL swap got %h exp %h", {tos, depth, overflow, underflow}, {8'd4, 4'd2, 2'b00}); end
        issue(3'b100, 8'd0);
        n_cmp++; if ({tos, depth} !== {8'd4, 4'd3}) begin n_err++; $display("FAIL dup got %h exp 043", {tos, depth}); end
`else
        n_cmp++; if ({tos, depth, overflow, underflow} !== {8'd9, 4'd2, 2'b11}) begin n_err++; $display("FAIL swap_illegal got %h exp %h", {tos, depth, overflow, underflow}, {8'd9, 4'd2, 2'b11}); end
        issue(3'b100, 8'd0);
        n_cmp++; if ({tos, depth} !== {8'd9, 4'd2}) begin n_err++; $display("FAIL dup_illegal got %h exp 092", {tos, depth}); end
`endif
    endtask

    initial begin
        test_reset();
        test_binop();
        test_overflow();
        test_underflow();
        test_pop();
        test_reset_exec();
        test_dup_swap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
